// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter: merges LSU, ALU and multicycle results onto two register-file write ports.
// Optional stall counter enabled by defining RISCV_WB_PERF_EN.
module riscv_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_we_i,
  input  logic [ADDR_WIDTH-1:0]        alu_waddr_i,
  input  logic [DATA_WIDTH-1:0]        alu_wdata_i,
  input  logic                         alu_wtag_i,
  input  logic                         lsu_we_i,
  input  logic [ADDR_WIDTH-1:0]        lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]        lsu_wdata_i,
  input  logic                         lsu_wtag_i,
  input  logic                         mc_valid_i,
  output logic                         mc_ready_o,
  input  logic [ADDR_WIDTH-1:0]        mc_waddr_i,
  input  logic [DATA_WIDTH-1:0]        mc_wdata_i,
  input  logic                         mc_wtag_i,
  output logic                         we_a_o,
  output logic [ADDR_WIDTH-1:0]        waddr_a_o,
  output logic [DATA_WIDTH-1:0]        wdata_a_o,
  output logic                         wtag_a_o,
  output logic                         we_b_o,
  output logic [ADDR_WIDTH-1:0]        waddr_b_o,
  output logic [DATA_WIDTH-1:0]        wdata_b_o,
  output logic                         wtag_b_o,
  output logic [(2**ADDR_WIDTH)-1:0]   pend_o,
  output logic [31:0]                  perf_stall_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] f_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] f_data_q [FIFO_DEPTH];
  logic                  f_tag_q  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] f_vld_q, f_vld_d;
  logic [FIFO_DEPTH-1:0] f_kill_q, f_kill_d;
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d, rd1;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NR-1:0]         pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] addr_nx [FIFO_DEPTH];

  logic                  we_a_q, we_a_d, we_b_q, we_b_d;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
  logic                  wtag_a_q, wtag_a_d, wtag_b_q, wtag_b_d;

  logic                  alu_v, lsu_v, mc_hit, mc_dead;
  logic [FIFO_DEPTH-1:0] slot_hit;
  logic                  h0_vld, h1_vld, h0_dead, h1_dead;
  logic                  b_av, a_av, b_av1, a_av1, b_av2, a_av2;
  logic                  h0_b, h0_a, h1_b, h1_a, pop0, pop1;
  logic                  drain, mc_port_free, mc_ready, mc_fire, mc_issue, mc_push, mc_b, mc_a;

  // Address 0 writes are swallowed, so they neither occupy a port nor kill anything.
  assign alu_v   = alu_we_i & (alu_waddr_i != '0);
  assign lsu_v   = lsu_we_i & (lsu_waddr_i != '0);
  assign mc_hit  = (alu_v & (mc_waddr_i == alu_waddr_i)) | (lsu_v & (mc_waddr_i == lsu_waddr_i));
  assign mc_dead = (mc_waddr_i == '0) | mc_hit;

  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_hit[i] = (alu_v & (f_addr_q[i] == alu_waddr_i)) | (lsu_v & (f_addr_q[i] == lsu_waddr_i));
    end
  end

  assign rd1     = rd_q + PW'(1);
  assign h0_vld  = (cnt_q >= CW'(1));
  assign h1_vld  = (cnt_q >= CW'(2));
  // Entries hit by a same-cycle ALU/LSU write are treated as already killed.
  assign h0_dead = f_kill_q[rd_q] | slot_hit[rd_q];
  assign h1_dead = f_kill_q[rd1] | slot_hit[rd1];

  assign b_av  = ~alu_v;
  assign a_av  = ~lsu_v;
  assign h0_b  = h0_vld & ~h0_dead & b_av;
  assign h0_a  = h0_vld & ~h0_dead & ~b_av & a_av;
  assign pop0  = h0_vld & (h0_dead | h0_b | h0_a);
  assign b_av1 = b_av & ~h0_b;
  assign a_av1 = a_av & ~h0_a;
  assign h1_b  = pop0 & h1_vld & ~h1_dead & b_av1;
  assign h1_a  = pop0 & h1_vld & ~h1_dead & ~b_av1 & a_av1;
  assign pop1  = pop0 & h1_vld & (h1_dead | h1_b | h1_a);
  assign b_av2 = b_av1 & ~h1_b;
  assign a_av2 = a_av1 & ~h1_a;

  // The mc input may only use a port once every buffered entry retires this cycle.
  assign drain        = (cnt_q == CW'(0)) | ((cnt_q == CW'(1)) & pop0) | ((cnt_q == CW'(2)) & pop1);
  assign mc_port_free = drain & (b_av2 | a_av2);
  assign mc_ready     = mc_port_free | (cnt_q != CW'(FIFO_DEPTH));
  assign mc_fire      = mc_valid_i & mc_ready;
  assign mc_issue     = mc_fire & ~mc_dead & mc_port_free;
  assign mc_push      = mc_fire & ~mc_dead & ~mc_issue;
  assign mc_b         = mc_issue & b_av2;
  assign mc_a         = mc_issue & ~b_av2 & a_av2;
  assign mc_ready_o   = mc_ready;

  always_comb begin
    we_b_d    = 1'b0;
    waddr_b_d = '0;
    wdata_b_d = '0;
    wtag_b_d  = 1'b0;
    if (alu_v) begin
      we_b_d    = 1'b1;
      waddr_b_d = alu_waddr_i;
      wdata_b_d = alu_wdata_i;
      wtag_b_d  = alu_wtag_i;
    end else if (h0_b) begin
      we_b_d    = 1'b1;
      waddr_b_d = f_addr_q[rd_q];
      wdata_b_d = f_data_q[rd_q];
      wtag_b_d  = f_tag_q[rd_q];
    end else if (h1_b) begin
      we_b_d    = 1'b1;
      waddr_b_d = f_addr_q[rd1];
      wdata_b_d = f_data_q[rd1];
      wtag_b_d  = f_tag_q[rd1];
    end else if (mc_b) begin
      we_b_d    = 1'b1;
      waddr_b_d = mc_waddr_i;
      wdata_b_d = mc_wdata_i;
      wtag_b_d  = mc_wtag_i;
    end else begin
      we_b_d    = 1'b0;
    end
  end

  always_comb begin
    we_a_d    = 1'b0;
    waddr_a_d = '0;
    wdata_a_d = '0;
    wtag_a_d  = 1'b0;
    if (lsu_v) begin
      we_a_d    = 1'b1;
      waddr_a_d = lsu_waddr_i;
      wdata_a_d = lsu_wdata_i;
      wtag_a_d  = lsu_wtag_i;
    end else if (h0_a) begin
      we_a_d    = 1'b1;
      waddr_a_d = f_addr_q[rd_q];
      wdata_a_d = f_data_q[rd_q];
      wtag_a_d  = f_tag_q[rd_q];
    end else if (h1_a) begin
      we_a_d    = 1'b1;
      waddr_a_d = f_addr_q[rd1];
      wdata_a_d = f_data_q[rd1];
      wtag_a_d  = f_tag_q[rd1];
    end else if (mc_a) begin
      we_a_d    = 1'b1;
      waddr_a_d = mc_waddr_i;
      wdata_a_d = mc_wdata_i;
      wtag_a_d  = mc_wtag_i;
    end else begin
      we_a_d    = 1'b0;
    end
  end

  always_comb begin
    f_kill_d = f_kill_q | (slot_hit & f_vld_q);
    f_vld_d  = f_vld_q;
    if (pop0) begin
      f_vld_d[rd_q] = 1'b0;
    end else begin
      f_vld_d[rd_q] = f_vld_q[rd_q];
    end
    if (pop1) begin
      f_vld_d[rd1] = 1'b0;
    end else begin
      f_vld_d[rd1] = f_vld_d[rd1];
    end
    if (mc_push) begin
      f_vld_d[wr_q]  = 1'b1;
      f_kill_d[wr_q] = 1'b0;
    end else begin
      f_vld_d[wr_q]  = f_vld_d[wr_q];
    end
    rd_d  = rd_q + PW'(pop0) + PW'(pop1);
    wr_d  = wr_q + PW'(mc_push);
    cnt_d = cnt_q - CW'(pop0) - CW'(pop1) + CW'(mc_push);
  end

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      addr_nx[i] = (mc_push && (wr_q == PW'(i))) ? mc_waddr_i : f_addr_q[i];
    end
  end

  // Scoreboard reflects the FIFO state after this cycle's push/kill/pop.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (f_vld_d[i] && !f_kill_d[i]) begin
        pend_d[addr_nx[i]] = 1'b1;
      end else begin
        pend_d = pend_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mc_push) begin
      f_addr_q[wr_q] <= mc_waddr_i;
      f_data_q[wr_q] <= mc_wdata_i;
      f_tag_q[wr_q]  <= mc_wtag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      wtag_a_q  <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      wtag_b_q  <= 1'b0;
      pend_q    <= '0;
      f_vld_q   <= '0;
      f_kill_q  <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      we_a_q    <= we_a_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      wtag_a_q  <= wtag_a_d;
      we_b_q    <= we_b_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
      wtag_b_q  <= wtag_b_d;
      pend_q    <= pend_d;
      f_vld_q   <= f_vld_d;
      f_kill_q  <= f_kill_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign we_a_o    = we_a_q;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign wtag_a_o  = wtag_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;
  assign wtag_b_o  = wtag_b_q;
  assign pend_o    = pend_q;

`ifdef RISCV_WB_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of cycles where a multicycle result is held off.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 32'h0;
    end else if (mc_valid_i && !mc_ready && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end else begin
      perf_q <= perf_q;
    end
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: single-cycle vector table plus multi-cycle FIFO sequences.
module tb_riscv_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_we_i, lsu_we_i, mc_valid_i, mc_ready_o;
  logic [AW-1:0] alu_waddr_i, lsu_waddr_i, mc_waddr_i;
  logic [DW-1:0] alu_wdata_i, lsu_wdata_i, mc_wdata_i;
  logic          alu_wtag_i, lsu_wtag_i, mc_wtag_i;
  logic          we_a_o, we_b_o, wtag_a_o, wtag_b_o;
  logic [AW-1:0] waddr_a_o, waddr_b_o;
  logic [DW-1:0] wdata_a_o, wdata_b_o;
  logic [31:0]   pend_o;
  logic [31:0]   perf_stall_cnt_o;

  riscv_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i), .alu_wtag_i(alu_wtag_i),
    .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_wtag_i(lsu_wtag_i),
    .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o),
    .mc_waddr_i(mc_waddr_i), .mc_wdata_i(mc_wdata_i), .mc_wtag_i(mc_wtag_i),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .wtag_a_o(wtag_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .wtag_b_o(wtag_b_o),
    .pend_o(pend_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Tags on every source follow bit 0 of the data, so expected tags come from expected data.
  typedef struct {
    logic alu_we; logic [AW-1:0] alu_a; logic [DW-1:0] alu_d;
    logic lsu_we; logic [AW-1:0] lsu_a; logic [DW-1:0] lsu_d;
    logic mc_v;   logic [AW-1:0] mc_a;  logic [DW-1:0] mc_d;
    logic ea_we;  logic [AW-1:0] ea_a;  logic [DW-1:0] ea_d;
    logic eb_we;  logic [AW-1:0] eb_a;  logic [DW-1:0] eb_d;
    logic e_rdy;  logic [31:0] e_pend;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  vec_t sb_q[$];
  vec_t tbl[10];
  logic [31:0] exp_pend;
  logic [31:0] exp_perf;

  function automatic vec_t mkv(
    input logic alu_we, input logic [AW-1:0] alu_a, input logic [DW-1:0] alu_d,
    input logic lsu_we, input logic [AW-1:0] lsu_a, input logic [DW-1:0] lsu_d,
    input logic mc_v,   input logic [AW-1:0] mc_a,  input logic [DW-1:0] mc_d,
    input logic ea_we,  input logic [AW-1:0] ea_a,  input logic [DW-1:0] ea_d,
    input logic eb_we,  input logic [AW-1:0] eb_a,  input logic [DW-1:0] eb_d,
    input logic e_rdy,  input logic [31:0] e_pend);
    vec_t v;
    v.alu_we = alu_we; v.alu_a = alu_a; v.alu_d = alu_d;
    v.lsu_we = lsu_we; v.lsu_a = lsu_a; v.lsu_d = lsu_d;
    v.mc_v = mc_v; v.mc_a = mc_a; v.mc_d = mc_d;
    v.ea_we = ea_we; v.ea_a = ea_a; v.ea_d = ea_d;
    v.eb_we = eb_we; v.eb_a = eb_a; v.eb_d = eb_d;
    v.e_rdy = e_rdy; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    alu_we_i = v.alu_we; alu_waddr_i = v.alu_a; alu_wdata_i = v.alu_d; alu_wtag_i = v.alu_d[0];
    lsu_we_i = v.lsu_we; lsu_waddr_i = v.lsu_a; lsu_wdata_i = v.lsu_d; lsu_wtag_i = v.lsu_d[0];
    mc_valid_i = v.mc_v; mc_waddr_i = v.mc_a; mc_wdata_i = v.mc_d; mc_wtag_i = v.mc_d[0];
  endtask

  task automatic step(input string nm, input vec_t v);
    vec_t e;
    drive(v);
    #1;
    chk({nm, " mc_ready"}, 32'(mc_ready_o), 32'(v.e_rdy));
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({nm, " we_a"}, 32'(we_a_o), 32'(e.ea_we));
    if (e.ea_we) begin
      chk({nm, " waddr_a"}, 32'(waddr_a_o), 32'(e.ea_a));
      chk({nm, " wdata_a"}, wdata_a_o, e.ea_d);
      chk({nm, " wtag_a"}, 32'(wtag_a_o), 32'(e.ea_d[0]));
    end
    chk({nm, " we_b"}, 32'(we_b_o), 32'(e.eb_we));
    if (e.eb_we) begin
      chk({nm, " waddr_b"}, 32'(waddr_b_o), 32'(e.eb_a));
      chk({nm, " wdata_b"}, wdata_b_o, e.eb_d);
      chk({nm, " wtag_b"}, 32'(wtag_b_o), 32'(e.eb_d[0]));
    end
    chk({nm, " pend"}, pend_o, e.e_pend);
  endtask

  initial begin
    rst = 1'b1;
    drive(mkv(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset we_a", 32'(we_a_o), 32'd0);
    chk("reset we_b", 32'(we_b_o), 32'd0);
    chk("reset pend", pend_o, 32'd0);
    chk("reset perf", perf_stall_cnt_o, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset mc_ready", 32'(mc_ready_o), 32'd1);

    // alu | lsu | mc | expected port A | expected port B | ready | pend
    tbl[0] = mkv(1,5,32'hA5, 0,0,0,       0,0,0,        0,0,0,         1,5,32'hA5,  1,0);
    tbl[1] = mkv(0,0,0,      1,3,32'h33,  0,0,0,        1,3,32'h33,    0,0,0,       1,0);
    tbl[2] = mkv(1,4,32'h44, 1,4,32'h45,  0,0,0,        1,4,32'h45,    1,4,32'h44,  1,0);
    tbl[3] = mkv(0,0,0,      0,0,0,       1,7,32'h77,   0,0,0,         1,7,32'h77,  1,0);
    tbl[4] = mkv(1,1,32'h11, 0,0,0,       1,2,32'h23,   1,2,32'h23,    1,1,32'h11,  1,0);
    tbl[5] = mkv(0,0,0,      1,1,32'h12,  1,2,32'h24,   1,1,32'h12,    1,2,32'h24,  1,0);
    tbl[6] = mkv(1,0,32'h99, 0,0,0,       0,0,0,        0,0,0,         0,0,0,       1,0);
    tbl[7] = mkv(0,0,0,      1,0,32'h98,  1,0,32'h97,   0,0,0,         0,0,0,       1,0);
    tbl[8] = mkv(0,0,0,      0,0,0,       0,0,0,        0,0,0,         0,0,0,       1,0);
    tbl[9] = mkv(1,6,32'h61, 0,0,0,       1,6,32'h66,   0,0,0,         1,6,32'h61,  1,0);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Both ports busy: mc parks in the FIFO, then retires on the free port A.
    step("t2_c1", mkv(1,4,32'h44, 1,3,32'h33, 1,7,32'h77, 1,3,32'h33, 1,4,32'h44, 1,32'h80));
    step("t2_c2", mkv(1,10,32'hAA, 0,0,0, 0,0,0, 1,7,32'h77, 1,10,32'hAA, 1,32'h0));

    // Fill to DEPTH with ports busy, then two stall cycles.
    exp_pend = 32'h0;
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0] ma;
      ma = (k < 4) ? AW'(11 + k) : AW'(15);
      if (k < 4) exp_pend = exp_pend | (32'h1 << (11 + k));
      step($sformatf("t3_c%0d", k),
           mkv(1,20,32'h100 + 32'(k), 1,21,32'h300 + 32'(k), 1,ma,32'h200 + 32'(ma),
               1,21,32'h300 + 32'(k), 1,20,32'h100 + 32'(k), (k < 4) ? 1'b1 : 1'b0, exp_pend));
    end
`ifdef RISCV_WB_PERF_EN
    exp_perf = 32'd2;
`else
    exp_perf = 32'd0;
`endif
    chk("t3 perf", perf_stall_cnt_o, exp_perf);
    step("t3_drain1", mkv(0,0,0, 0,0,0, 0,0,0, 1,12,32'h20C, 1,11,32'h20B, 0,(32'h1 << 13) | (32'h1 << 14)));
    step("t3_drain2", mkv(0,0,0, 0,0,0, 0,0,0, 1,14,32'h20E, 1,13,32'h20D, 1,32'h0));

    // Entry 9 is killed behind a blocked head, then pops silently.
    step("t4_c1", mkv(1,22,32'h16, 1,23,32'h17, 1,8,32'h88, 1,23,32'h17, 1,22,32'h16, 1,32'h100));
    step("t4_c2", mkv(1,25,32'h19, 1,26,32'h1A, 1,9,32'h99, 1,26,32'h1A, 1,25,32'h19, 1,32'h300));
    step("t4_c3", mkv(1,9,32'hDE, 1,27,32'h1B, 0,0,0, 1,27,32'h1B, 1,9,32'hDE, 1,32'h100));
    step("t4_c4", mkv(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,8,32'h88, 1,32'h0));
    step("t4_c5", mkv(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,32'h0));

    // Address-0 mc under busy ports must not create an entry.
    step("t5_c1", mkv(1,28,32'h1C, 1,29,32'h1D, 1,0,32'h55, 1,29,32'h1D, 1,28,32'h1C, 1,32'h0));
    step("t5_c2", mkv(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,32'h0));

    // Reset with three buffered entries.
    exp_pend = 32'h0;
    for (int k = 0; k < 3; k++) begin
      exp_pend = exp_pend | (32'h1 << (17 + k));
      step($sformatf("t6_fill%0d", k),
           mkv(1,20,32'h40 + 32'(k), 1,21,32'h50 + 32'(k), 1,AW'(17 + k),32'h60 + 32'(k),
               1,21,32'h50 + 32'(k), 1,20,32'h40 + 32'(k), 1, exp_pend));
    end
    rst = 1'b1;
    drive(mkv(1,5,32'h5, 1,6,32'h6, 1,7,32'h7, 0,0,0, 0,0,0, 0,0));
    @(posedge clk);
    #1;
    chk("t6 we_a", 32'(we_a_o), 32'd0);
    chk("t6 we_b", 32'(we_b_o), 32'd0);
    chk("t6 pend", pend_o, 32'd0);
    chk("t6 perf", perf_stall_cnt_o, 32'd0);
    rst = 1'b0;
    step("t6_after", mkv(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
